// File: rtl/mips_multicycle_ctrl_if.sv
// Control/status bundle between the multicycle sequencer (master) and the MIPS datapath (slave).
// Build option MC_PERF_COUNT_EN adds the cycle_count / instr_count performance outputs.
interface mips_multicycle_ctrl_if;
  logic       run;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero_flag;
  logic       mem_ready;
  logic       pc_write;
  logic       pc_write_cond;
  logic [1:0] pc_src;
  logic       ir_write;
  logic       iord;
  logic       mem_read;
  logic       mem_write;
  logic       memtoreg;
  logic       regdst;
  logic       regwrite;
  logic       jal_link;
  logic       alusrc_a;
  logic [1:0] alusrc_b;
  logic [3:0] ALUOp;
  logic       bne;
  logic [3:0] state;
  logic       fault;
`ifdef MC_PERF_COUNT_EN
  logic [31:0] cycle_count;
  logic [31:0] instr_count;
`endif

  modport master (
`ifdef MC_PERF_COUNT_EN
    output cycle_count,
    output instr_count,
`endif
    input  run,
    input  opcode,
    input  funct,
    input  zero_flag,
    input  mem_ready,
    output pc_write,
    output pc_write_cond,
    output pc_src,
    output ir_write,
    output iord,
    output mem_read,
    output mem_write,
    output memtoreg,
    output regdst,
    output regwrite,
    output jal_link,
    output alusrc_a,
    output alusrc_b,
    output ALUOp,
    output bne,
    output state,
    output fault
  );

  modport slave (
`ifdef MC_PERF_COUNT_EN
    input  cycle_count,
    input  instr_count,
`endif
    output run,
    output opcode,
    output funct,
    output zero_flag,
    output mem_ready,
    input  pc_write,
    input  pc_write_cond,
    input  pc_src,
    input  ir_write,
    input  iord,
    input  mem_read,
    input  mem_write,
    input  memtoreg,
    input  regdst,
    input  regwrite,
    input  jal_link,
    input  alusrc_a,
    input  alusrc_b,
    input  ALUOp,
    input  bne,
    input  state,
    input  fault
  );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS sequencer: shared memory port with ready handshake, one reused ALU, sticky fault.
// Build option MC_PERF_COUNT_EN adds free-running cycle and retired-instruction counters.
module mips_multicycle_ctrl #(
  parameter int MAX_WAIT = 15,
  parameter int WAIT_W   = 8
) (
  input  logic                   clock,
  input  logic                   Reset,
  mips_multicycle_ctrl_if.master bus
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC   = 4'd7,
    S_RWB    = 4'd8,
    S_BRANCH = 4'd9,
    S_JUMP   = 4'd10,
    S_IMMEX  = 4'd11,
    S_IMMWB  = 4'd12,
    S_JAL    = 4'd13,
    S_FAULT  = 4'd15
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0001;
  localparam logic [3:0] ALU_FUNCT = 4'b0010;

  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

  state_e              state_q, state_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic                mem_state;
  logic                timeout;
  state_e              after_instr;

  // funct and zero_flag are consumed by the datapath/ALU decode, not by the sequencer
  logic unused_inputs;
  assign unused_inputs = ^{bus.funct, bus.zero_flag};

  assign mem_state   = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
  // the MAX_WAIT-th unanswered cycle faults; a ready in that same cycle still completes
  assign timeout     = mem_state && !bus.mem_ready && (wait_q == WAIT_LAST);
  assign after_instr = bus.run ? S_FETCH : S_IDLE;

  always_ff @(posedge clock) begin
    if (Reset) begin
      state_q <= S_IDLE;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (bus.run) state_d = S_FETCH;
      S_FETCH: begin
        if (bus.mem_ready)  state_d = S_DECODE;
        else if (timeout)   state_d = S_FAULT;
      end
      S_DECODE: begin
        unique case (bus.opcode)
          OP_RTYPE:       state_d = S_EXEC;
          OP_LW, OP_SW:   state_d = S_MEMADR;
          OP_BEQ, OP_BNE: state_d = S_BRANCH;
          OP_ADDI:        state_d = S_IMMEX;
          OP_J:           state_d = S_JUMP;
          OP_JAL:         state_d = S_JAL;
          default:        state_d = S_FAULT;
        endcase
      end
      S_MEMADR: state_d = (bus.opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD: begin
        if (bus.mem_ready)  state_d = S_MEMWB;
        else if (timeout)   state_d = S_FAULT;
      end
      S_MEMWR: begin
        if (bus.mem_ready)  state_d = after_instr;
        else if (timeout)   state_d = S_FAULT;
      end
      S_EXEC:   state_d = S_RWB;
      S_IMMEX:  state_d = S_IMMWB;
      S_MEMWB, S_RWB, S_BRANCH, S_JUMP, S_IMMWB, S_JAL:
                state_d = after_instr;
      S_FAULT:  state_d = S_FAULT;
      default:  state_d = S_FAULT;
    endcase
  end

  // Counter only advances while a memory state is held; any transition clears it.
  always_comb begin
    wait_d = '0;
    if (mem_state && !bus.mem_ready && (state_d == state_q)) begin
      wait_d = wait_q + 1'b1;
    end
  end

  always_comb begin
    bus.pc_write      = 1'b0;
    bus.pc_write_cond = 1'b0;
    bus.pc_src        = 2'b00;
    bus.ir_write      = 1'b0;
    bus.iord          = 1'b0;
    bus.mem_read      = 1'b0;
    bus.mem_write     = 1'b0;
    bus.memtoreg      = 1'b0;
    bus.regdst        = 1'b0;
    bus.regwrite      = 1'b0;
    bus.jal_link      = 1'b0;
    bus.alusrc_a      = 1'b0;
    bus.alusrc_b      = 2'b00;
    bus.ALUOp         = ALU_ADD;
    bus.bne           = 1'b0;
    bus.fault         = 1'b0;
    bus.state         = state_q;
    unique case (state_q)
      S_FETCH: begin
        bus.mem_read = 1'b1;
        bus.alusrc_b = 2'b01;
        bus.ir_write = bus.mem_ready;
        bus.pc_write = bus.mem_ready;
      end
      S_DECODE: bus.alusrc_b = 2'b11;
      S_MEMADR, S_IMMEX: begin
        bus.alusrc_a = 1'b1;
        bus.alusrc_b = 2'b10;
      end
      S_MEMRD: begin
        bus.iord     = 1'b1;
        bus.mem_read = 1'b1;
      end
      S_MEMWB: begin
        bus.regwrite = 1'b1;
        bus.memtoreg = 1'b1;
      end
      S_MEMWR: begin
        bus.iord      = 1'b1;
        bus.mem_write = 1'b1;
      end
      S_EXEC: begin
        bus.alusrc_a = 1'b1;
        bus.ALUOp    = ALU_FUNCT;
      end
      S_RWB: begin
        bus.regwrite = 1'b1;
        bus.regdst   = 1'b1;
      end
      S_BRANCH: begin
        bus.alusrc_a      = 1'b1;
        bus.ALUOp         = ALU_SUB;
        bus.pc_write_cond = 1'b1;
        bus.pc_src        = 2'b01;
        bus.bne           = bus.opcode[0];
      end
      S_IMMWB:  bus.regwrite = 1'b1;
      S_JUMP: begin
        bus.pc_write = 1'b1;
        bus.pc_src   = 2'b10;
      end
      S_JAL: begin
        bus.pc_write = 1'b1;
        bus.pc_src   = 2'b10;
        bus.regwrite = 1'b1;
        bus.jal_link = 1'b1;
      end
      S_FAULT:  bus.fault = 1'b1;
      default: ;
    endcase
  end

`ifdef MC_PERF_COUNT_EN
  logic [31:0] cycle_count_q, cycle_count_d;
  logic [31:0] instr_count_q, instr_count_d;
  logic        busy;
  logic        instr_done;

  assign busy       = (state_q != S_IDLE) && (state_q != S_FAULT);
  assign instr_done = (state_q == S_MEMWB) || (state_q == S_RWB) || (state_q == S_BRANCH) ||
                      (state_q == S_JUMP) || (state_q == S_IMMWB) || (state_q == S_JAL) ||
                      ((state_q == S_MEMWR) && bus.mem_ready);

  always_comb begin
    cycle_count_d = cycle_count_q + 32'(busy);
    instr_count_d = instr_count_q + 32'(instr_done);
  end

  always_ff @(posedge clock) begin
    if (Reset) begin
      cycle_count_q <= '0;
      instr_count_q <= '0;
    end else begin
      cycle_count_q <= cycle_count_d;
      instr_count_q <= instr_count_d;
    end
  end

  assign bus.cycle_count = cycle_count_q;
  assign bus.instr_count = instr_count_q;
`endif

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl: per-instruction state paths are planned from opcode and
// memory latency, each cycle's strobes come from the control table, plus literal spot checks.
module tb_mips_multicycle_ctrl;

  localparam int MAXW = 4;

  localparam logic [3:0] ST_IDLE   = 4'd0;
  localparam logic [3:0] ST_FETCH  = 4'd1;
  localparam logic [3:0] ST_DECODE = 4'd2;
  localparam logic [3:0] ST_MEMADR = 4'd3;
  localparam logic [3:0] ST_MEMRD  = 4'd4;
  localparam logic [3:0] ST_MEMWB  = 4'd5;
  localparam logic [3:0] ST_MEMWR  = 4'd6;
  localparam logic [3:0] ST_EXEC   = 4'd7;
  localparam logic [3:0] ST_RWB    = 4'd8;
  localparam logic [3:0] ST_BRANCH = 4'd9;
  localparam logic [3:0] ST_JUMP   = 4'd10;
  localparam logic [3:0] ST_IMMEX  = 4'd11;
  localparam logic [3:0] ST_IMMWB  = 4'd12;
  localparam logic [3:0] ST_JAL    = 4'd13;
  localparam logic [3:0] ST_FAULT  = 4'd15;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_src;
    logic       ir_write;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       memtoreg;
    logic       regdst;
    logic       regwrite;
    logic       jal_link;
    logic       alusrc_a;
    logic [1:0] alusrc_b;
    logic [3:0] aluop;
    logic       bne;
    logic       fault;
  } outs_t;

  typedef struct {
    logic [3:0] st;
    outs_t      o;
  } rec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       chk_en = 1'b0;
  logic [3:0] exp_state;
  int         n_cmp = 0;
  int         n_bad = 0;
  rec_t       hist[$];

  mips_multicycle_ctrl_if bus ();

  mips_multicycle_ctrl #(.MAX_WAIT(MAXW), .WAIT_W(8)) dut (
    .clock (clk),
    .Reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Control table: what each state must drive, given the IR opcode and the memory handshake.
  function automatic outs_t model(input logic [3:0] st, input logic [5:0] op, input logic mr);
    outs_t o;
    o = '0;
    case (st)
      ST_FETCH:  begin o.mem_read = 1; o.alusrc_b = 2'b01; o.ir_write = mr; o.pc_write = mr; end
      ST_DECODE: o.alusrc_b = 2'b11;
      ST_MEMADR: begin o.alusrc_a = 1; o.alusrc_b = 2'b10; end
      ST_MEMRD:  begin o.iord = 1; o.mem_read = 1; end
      ST_MEMWB:  begin o.regwrite = 1; o.memtoreg = 1; end
      ST_MEMWR:  begin o.iord = 1; o.mem_write = 1; end
      ST_EXEC:   begin o.alusrc_a = 1; o.aluop = 4'b0010; end
      ST_RWB:    begin o.regwrite = 1; o.regdst = 1; end
      ST_BRANCH: begin o.alusrc_a = 1; o.aluop = 4'b0001; o.pc_write_cond = 1;
                       o.pc_src = 2'b01; o.bne = op[0]; end
      ST_IMMEX:  begin o.alusrc_a = 1; o.alusrc_b = 2'b10; end
      ST_IMMWB:  o.regwrite = 1;
      ST_JUMP:   begin o.pc_write = 1; o.pc_src = 2'b10; end
      ST_JAL:    begin o.pc_write = 1; o.pc_src = 2'b10; o.regwrite = 1; o.jal_link = 1; end
      ST_FAULT:  o.fault = 1;
      default: ;
    endcase
    return o;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      outs_t act, expv;
      act = {bus.pc_write, bus.pc_write_cond, bus.pc_src, bus.ir_write, bus.iord, bus.mem_read,
             bus.mem_write, bus.memtoreg, bus.regdst, bus.regwrite, bus.jal_link, bus.alusrc_a,
             bus.alusrc_b, bus.ALUOp, bus.bne, bus.fault};
      expv = model(exp_state, bus.opcode, bus.mem_ready);
      n_cmp++;
      if (bus.state !== exp_state || act !== expv) begin
        n_bad++;
        $display("FAIL cycle t=%0t state=%0d want_state=%0d outs=%h want_outs=%h",
                 $time, bus.state, exp_state, act, expv);
      end
      hist.push_back('{st: bus.state, o: act});
    end
  end

  task automatic chk(input string name, input int act, input int want);
    n_cmp++;
    if (act != want) begin
      n_bad++;
      $display("FAIL %s got=%0d want=%0d", name, act, want);
    end
  endtask

  task automatic step(input logic r, input logic rn, input logic mr, input logic [3:0] es);
    rst           = r;
    bus.run       = rn;
    bus.mem_ready = mr;
    bus.zero_flag = 1'($urandom_range(1));
    exp_state     = es;
    chk_en        = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Entered with the DUT in FETCH; fl/ml are unanswered cycles before mem_ready in fetch/data access.
  task automatic do_instr(input logic [5:0] op, input int fl, input int ml, input logic keep);
    bus.opcode = op;
    bus.funct  = 6'($urandom);
    for (int i = 0; i < fl; i++) step(1'b0, 1'b1, 1'b0, ST_FETCH);
    step(1'b0, 1'b1, 1'b1, ST_FETCH);
    step(1'b0, 1'b1, 1'b1, ST_DECODE);
    case (op)
      6'b000000: begin step(1'b0, keep, 1'b1, ST_EXEC); step(1'b0, keep, 1'b1, ST_RWB); end
      6'b100011: begin
        step(1'b0, keep, 1'b1, ST_MEMADR);
        for (int i = 0; i < ml; i++) step(1'b0, keep, 1'b0, ST_MEMRD);
        step(1'b0, keep, 1'b1, ST_MEMRD);
        step(1'b0, keep, 1'b1, ST_MEMWB);
      end
      6'b101011: begin
        step(1'b0, keep, 1'b1, ST_MEMADR);
        for (int i = 0; i < ml; i++) step(1'b0, keep, 1'b0, ST_MEMWR);
        step(1'b0, keep, 1'b1, ST_MEMWR);
      end
      6'b000100, 6'b000101: step(1'b0, keep, 1'b1, ST_BRANCH);
      6'b001000: begin step(1'b0, keep, 1'b1, ST_IMMEX); step(1'b0, keep, 1'b1, ST_IMMWB); end
      6'b000010: step(1'b0, keep, 1'b1, ST_JUMP);
      6'b000011: step(1'b0, keep, 1'b1, ST_JAL);
      default:   step(1'b0, 1'b1, 1'b1, ST_FAULT);
    endcase
  endtask

  function automatic int branch_bne();
    foreach (hist[i]) if (hist[i].st == ST_BRANCH) return int'(hist[i].o.bne);
    return -1;
  endfunction

  function automatic int count_state(input logic [3:0] s);
    int n = 0;
    foreach (hist[i]) if (hist[i].st == s) n++;
    return n;
  endfunction

  initial begin
    logic [19:0] trace;
    rst           = 1'b1;
    bus.run       = 1'b1;
    bus.opcode    = '0;
    bus.funct     = '0;
    bus.zero_flag = 1'b0;
    bus.mem_ready = 1'b1;
    @(posedge clk);
    #1;
    step(1'b1, 1'b1, 1'b1, ST_IDLE);
    chk("rst_state", int'(bus.state), 0);
    chk("rst_fault", int'(bus.fault), 0);

    hist.delete();
    step(1'b0, 1'b1, 1'b1, ST_IDLE);
    do_instr(6'b000000, 0, 0, 1'b1);
    chk("rtype_len", hist.size(), 5);
    trace = {hist[0].st, hist[1].st, hist[2].st, hist[3].st, hist[4].st};
    chk("rtype_trace", int'(trace), 32'h01278);
    chk("rtype_next", int'(bus.state), 1);

    hist.delete();
    do_instr(6'b100011, 0, 3, 1'b1);
    chk("lw_cycles", hist.size(), 8);
    chk("lw_memrd_cycles", count_state(ST_MEMRD), 4);

    hist.delete();
    do_instr(6'b000100, 0, 0, 1'b1);
    chk("beq_bne_bit", branch_bne(), 0);
    hist.delete();
    do_instr(6'b000101, 0, 0, 1'b1);
    chk("bne_bne_bit", branch_bne(), 1);

    do_instr(6'b001000, MAXW - 1, 0, 1'b1);
    do_instr(6'b000010, 0, 0, 1'b1);
    do_instr(6'b000011, 0, 0, 1'b1);
    chk("jal_next", int'(bus.state), 1);

    do_instr(6'b101011, 1, 2, 1'b0);
    chk("sw_rundrop_idle", int'(bus.state), 0);
    step(1'b0, 1'b0, 1'b1, ST_IDLE);
    step(1'b0, 1'b1, 1'b1, ST_IDLE);

    do_instr(6'b111111, 0, 0, 1'b1);
    chk("illegal_state", int'(bus.state), 15);
    chk("illegal_fault", int'(bus.fault), 1);
    step(1'b1, 1'b0, 1'b0, ST_FAULT);
    chk("illegal_rst_state", int'(bus.state), 0);
    step(1'b0, 1'b1, 1'b1, ST_IDLE);

    for (int i = 0; i < MAXW; i++) step(1'b0, 1'b1, 1'b0, ST_FETCH);
    chk("timeout_state", int'(bus.state), 15);
    chk("timeout_fault", int'(bus.fault), 1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, ST_FAULT);
    step(1'b1, 1'b1, 1'b1, ST_FAULT);
    chk("timeout_rst_state", int'(bus.state), 0);
    chk("timeout_rst_fault", int'(bus.fault), 0);
    step(1'b0, 1'b0, 1'b0, ST_IDLE);
    chk_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
Multicycle sequencing FSM for the MIPS datapath: one shared memory port, one ALU reused across cycles. It issues per-cycle control strobes (PC, IR, memory, register file, ALU operand/op selects) for R-type, lw, sw, beq, bne, addi, j and jal. It supports variable-latency memory through a ready handshake and flags a fault on memory timeout or illegal opcode. Sits beside the control/ula_ctrl decode path and replaces single-cycle sequencing.

Parameters:
MAX_WAIT, 15, max cycles a memory state waits for mem_ready before FAULT (1..255)
WAIT_W, 8, width of wait counter

Ports:
clock  in  1  system clock, rising edge
Reset  in  1  synchronous active-high reset
run  in  1  level; FETCH begins only while high
opcode  in  6  instruction[31:26] from IR
funct  in  6  instruction[5:0] from IR
zero_flag  in  1  ALU zero result
mem_ready  in  1  memory completes current access this cycle
pc_write  out  1  unconditional PC load
pc_write_cond  out  1  PC load if branch condition holds
pc_src  out  2  00 ALU result, 01 ALUOut register, 10 jump target
ir_write  out  1  latch instruction register
iord  out  1  0 address=PC, 1 address=ALUOut
mem_read  out  1  memory read request
mem_write  out  1  memory write request
memtoreg  out  1  write-back selects memory data
regdst  out  1  write address=rd (1) or rt (0)
regwrite  out  1  register file write enable
jal_link  out  1  force write address 31 and data PC+4
alusrc_a  out  1  0 PC, 1 register A
alusrc_b  out  2  00 regB, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
ALUOp  out  4  0000 add, 0001 sub, 0010 decode funct
bne  out  1  invert zero for branch condition
state  out  4  current state code
fault  out  1  sticky error flag

Behaviour:
- Synchronous Reset: state=IDLE, wait counter=0, fault=0; all strobes are Moore outputs of state, so all read 0 during and after reset; Reset mid-access aborts it with no writes.
- States/codes: IDLE 0, FETCH 1, DECODE 2, MEMADR 3, MEMRD 4, MEMWB 5, MEMWR 6, EXEC 7, RWB 8, BRANCH 9, JUMP 10, IMMEX 11, IMMWB 12, JAL 13, FAULT 15.
- IDLE: run=1 -> FETCH, else stay.
- FETCH: iord=0, mem_read=1, alusrc_a=0, alusrc_b=01, ALUOp=0000; ir_write and pc_write asserted only in the cycle mem_ready=1 (PC<=PC+4) -> DECODE.
- DECODE: alusrc_a=0, alusrc_b=11, ALUOp=0000 (branch target into ALUOut). Dispatch: 000000->EXEC; 100011/101011->MEMADR; 000100/000101->BRANCH; 001000->IMMEX; 000010->JUMP; 000011->JAL; other -> FAULT.
- MEMADR: alusrc_a=1, alusrc_b=10, add -> MEMRD (lw) or MEMWR (sw).
- MEMRD: iord=1, mem_read=1; on mem_ready -> MEMWB. MEMWB: regwrite=1, memtoreg=1, regdst=0 -> FETCH if run else IDLE.
- MEMWR: iord=1, mem_write=1; on mem_ready -> FETCH/IDLE.
- EXEC: alusrc_a=1, alusrc_b=00, ALUOp=0010 -> RWB: regwrite=1, regdst=1, memtoreg=0.
- BRANCH: alusrc_a=1, alusrc_b=00, ALUOp=0001, pc_write_cond=1, pc_src=01, bne=opcode[0].
- IMMEX: alusrc_a=1, alusrc_b=10, add -> IMMWB: regwrite=1, regdst=0.
- JUMP: pc_write=1, pc_src=10. JAL: pc_write=1, pc_src=10, regwrite=1, jal_link=1.
- Terminal states (MEMWB, MEMWR-done, RWB, BRANCH, JUMP, IMMWB, JAL) go to FETCH if run=1, else IDLE; run drop never aborts an instruction in flight.
- Wait counter: clears on entering FETCH/MEMRD/MEMWR; increments each cycle mem_ready=0 there; reaching MAX_WAIT with mem_ready still 0 -> FAULT. mem_ready same cycle as count hits MAX_WAIT: completion wins.
- mem_ready ignored outside memory states.
- FAULT: all strobes 0, fault=1, held until Reset. funct only consumed externally via ALUOp=0010.

Optional Feature:
MC_PERF_COUNT_EN: adds outputs cycle_count[31:0] (increments every non-IDLE, non-FAULT cycle) and instr_count[31:0] (increments on each instruction's terminal state); both clear on Reset, wrap at 2^32. Without macro these ports and counters do not exist.

Test Plan:
- Reset high 2 cycles, run=1, opcode=000000, mem_ready=1 -> state sequence 0,1,2,7,8,1; regwrite=1 only in RWB with regdst=1; ALUOp=0010 in EXEC.
- lw (100011), mem_ready delayed 3 cycles in MEMRD -> MEMRD held 4 cycles, mem_read=1 throughout, MEMWB regwrite=1 memtoreg=1; total 8 cycles.
- beq (000100) then bne (000101) -> BRANCH asserts pc_write_cond=1, pc_src=01, ALUOp=0001, bne=0 then 1.
- jal (000011) -> JAL: pc_write=1, pc_src=10, regwrite=1, jal_link=1; next state FETCH.
- MAX_WAIT=4, mem_ready=0 in FETCH -> FAULT (state=15, fault=1) after 4 cycles; stays until Reset, then state=0, fault=0.
- Illegal opcode 111111 in DECODE -> FAULT; run dropped during sw wait -> sw completes then IDLE.
